// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold handling
// and saturating bubble/flush performance counters.
module id_ex_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic             id_memread,
  input  logic             id_memtoreg,
  input  logic             id_memwrite,
  input  logic             id_alusrc,
  input  logic             id_regwrite,
  input  logic [1:0]       id_aluop,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      id_rs1_data,
  input  logic [31:0]      id_rs2_data,
  input  logic [31:0]      id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [3:0]       id_funct,
  input  logic             flush,
  input  logic             ex_hold,
  output logic             ex_valid,
  output logic             ex_branch,
  output logic             ex_memread,
  output logic             ex_memtoreg,
  output logic             ex_memwrite,
  output logic             ex_alusrc,
  output logic             ex_regwrite,
  output logic [1:0]       ex_aluop,
  output logic [31:0]      ex_pc,
  output logic [31:0]      ex_rs1_data,
  output logic [31:0]      ex_rs2_data,
  output logic [31:0]      ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [3:0]       ex_funct,
  output logic             stall,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
);

  logic uses_rs2;
  logic load_use;
  logic take_bubble;
  logic capture;

  always_comb begin
    uses_rs2    = !id_alusrc || id_memwrite;
    load_use    = id_valid && ex_valid && ex_memread && (ex_rd != '0) &&
                  ((ex_rd == id_rs1) || (uses_rs2 && (ex_rd == id_rs2)));
    take_bubble = !flush && !ex_hold && load_use;
    capture     = !flush && !ex_hold && !load_use;
    // ex_hold is ignored in reset; ex_valid is already 0 so load_use is too
    stall       = rst_n && !flush && (load_use || ex_hold);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_branch   <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_aluop    <= '0;
    end else if (flush || take_bubble) begin
      ex_valid    <= 1'b0;
      ex_branch   <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_aluop    <= '0;
    end else if (capture) begin
      ex_valid    <= id_valid;
      ex_branch   <= id_valid && id_branch;
      ex_memread  <= id_valid && id_memread;
      // memtoreg is meaningless without regwrite; stores/branches may carry junk
      ex_memtoreg <= id_valid && id_regwrite && id_memtoreg;
      ex_memwrite <= id_valid && id_memwrite;
      ex_alusrc   <= id_valid && id_alusrc;
      ex_regwrite <= id_valid && id_regwrite;
      ex_aluop    <= id_valid ? id_aluop : 2'b00;
    end
  end

  // Datapath fields only move on a real capture; bubbles leave them stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct    <= '0;
    end else if (capture) begin
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct    <= id_funct;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count <= '0;
      flush_count  <= '0;
    end else begin
      if (take_bubble && (bubble_count != '1)) bubble_count <= bubble_count + 1'b1;
      if (flush && (flush_count != '1))        flush_count  <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a stage-level model is compared every cycle,
// and hand-computed literals pin the interesting scenarios.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid, branch, memread, memtoreg, memwrite, alusrc, regwrite;
    logic [1:0]  aluop;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  funct;
  } stage_t;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   flush, ex_hold;
  stage_t id;

  stage_t      act, sat_act;
  logic        stall, sat_stall;
  logic [15:0] bubble_count, flush_count;
  logic [2:0]  sat_bubble_count, sat_flush_count;

  stage_t m = '0;
  int     mb = 0, mf = 0;
  int     checks = 0, errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id.valid), .id_branch(id.branch), .id_memread(id.memread),
    .id_memtoreg(id.memtoreg), .id_memwrite(id.memwrite), .id_alusrc(id.alusrc),
    .id_regwrite(id.regwrite), .id_aluop(id.aluop), .id_pc(id.pc),
    .id_rs1_data(id.rs1_data), .id_rs2_data(id.rs2_data), .id_imm(id.imm),
    .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd), .id_funct(id.funct),
    .flush(flush), .ex_hold(ex_hold),
    .ex_valid(act.valid), .ex_branch(act.branch), .ex_memread(act.memread),
    .ex_memtoreg(act.memtoreg), .ex_memwrite(act.memwrite), .ex_alusrc(act.alusrc),
    .ex_regwrite(act.regwrite), .ex_aluop(act.aluop), .ex_pc(act.pc),
    .ex_rs1_data(act.rs1_data), .ex_rs2_data(act.rs2_data), .ex_imm(act.imm),
    .ex_rs1(act.rs1), .ex_rs2(act.rs2), .ex_rd(act.rd), .ex_funct(act.funct),
    .stall(stall), .bubble_count(bubble_count), .flush_count(flush_count)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  id_ex_stage #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id.valid), .id_branch(id.branch), .id_memread(id.memread),
    .id_memtoreg(id.memtoreg), .id_memwrite(id.memwrite), .id_alusrc(id.alusrc),
    .id_regwrite(id.regwrite), .id_aluop(id.aluop), .id_pc(id.pc),
    .id_rs1_data(id.rs1_data), .id_rs2_data(id.rs2_data), .id_imm(id.imm),
    .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd), .id_funct(id.funct),
    .flush(flush), .ex_hold(ex_hold),
    .ex_valid(sat_act.valid), .ex_branch(sat_act.branch), .ex_memread(sat_act.memread),
    .ex_memtoreg(sat_act.memtoreg), .ex_memwrite(sat_act.memwrite),
    .ex_alusrc(sat_act.alusrc), .ex_regwrite(sat_act.regwrite), .ex_aluop(sat_act.aluop),
    .ex_pc(sat_act.pc), .ex_rs1_data(sat_act.rs1_data), .ex_rs2_data(sat_act.rs2_data),
    .ex_imm(sat_act.imm), .ex_rs1(sat_act.rs1), .ex_rs2(sat_act.rs2), .ex_rd(sat_act.rd),
    .ex_funct(sat_act.funct),
    .stall(sat_stall), .bubble_count(sat_bubble_count), .flush_count(sat_flush_count)
  );

  function automatic stage_t bubble_of(stage_t s);
    stage_t r = s;
    r.valid = 1'b0; r.branch = 1'b0; r.memread = 1'b0; r.memtoreg = 1'b0;
    r.memwrite = 1'b0; r.alusrc = 1'b0; r.regwrite = 1'b0; r.aluop = 2'b00;
    return r;
  endfunction

  function automatic logic hazard(stage_t d, stage_t e);
    logic reads2;
    reads2 = !d.alusrc || d.memwrite;
    return d.valid && e.valid && e.memread && (e.rd != 5'd0) &&
           ((e.rd == d.rs1) || (reads2 && (e.rd == d.rs2)));
  endfunction

  function automatic int sat(int v, int max);
    return (v > max) ? max : v;
  endfunction

  function automatic stage_t ins(logic br, logic mr, logic mtr, logic mw, logic as,
                                 logic rw, logic [1:0] op, logic [4:0] rs1,
                                 logic [4:0] rs2, logic [4:0] rd, logic [31:0] pc,
                                 logic [3:0] fn);
    stage_t s;
    s.valid = 1'b1; s.branch = br; s.memread = mr; s.memtoreg = mtr;
    s.memwrite = mw; s.alusrc = as; s.regwrite = rw; s.aluop = op;
    s.pc = pc; s.rs1_data = 32'hA000_0000 + 32'(rs1); s.rs2_data = 32'hB000_0000 + 32'(rs2);
    s.imm = pc ^ 32'h0000_0FF0; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.funct = fn;
    return s;
  endfunction

  function automatic stage_t lw(logic [4:0] rd, logic [4:0] rs1, logic [31:0] pc);
    return ins(0, 1, 1, 0, 1, 1, 2'b00, rs1, 5'd31, rd, pc, 4'h2);
  endfunction
  function automatic stage_t add(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                 logic [31:0] pc, logic [3:0] fn);
    return ins(0, 0, 0, 0, 0, 1, 2'b10, rs1, rs2, rd, pc, fn);
  endfunction
  function automatic stage_t addi(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2f,
                                  logic [31:0] pc);
    return ins(0, 0, 0, 0, 1, 1, 2'b00, rs1, rs2f, rd, pc, 4'h0);
  endfunction
  function automatic stage_t sw(logic [4:0] rs1, logic [4:0] rs2, logic [31:0] pc);
    return ins(0, 0, 1, 1, 1, 0, 2'b00, rs1, rs2, 5'd0, pc, 4'h2);
  endfunction

  task automatic chk(input string name, input logic [159:0] a, input logic [159:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, a, e);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    stage_t n;
    if (!rst_n) begin
      m <= '0; mb <= 0; mf <= 0;
    end else begin
      n = m;
      if (flush) begin
        n = bubble_of(m); mf <= mf + 1;
      end else if (ex_hold) begin
        n = m;
      end else if (hazard(id, m)) begin
        n = bubble_of(m); mb <= mb + 1;
      end else begin
        n = id.valid ? id : bubble_of(id);
        if (!id.regwrite) n.memtoreg = 1'b0;
      end
      m <= n;
    end
  end

  always @(negedge clk) begin
    chk("ex_fields", act, m);
    chk("sat_ex_fields", sat_act, m);
    chk("stall", stall, rst_n && !flush && (hazard(id, m) || ex_hold));
    chk("sat_stall", sat_stall, rst_n && !flush && (hazard(id, m) || ex_hold));
    chk("bubble_count", bubble_count, sat(mb, 65535));
    chk("flush_count", flush_count, sat(mf, 65535));
    chk("sat_bubble_count", sat_bubble_count, sat(mb, 7));
    chk("sat_flush_count", sat_flush_count, sat(mf, 7));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_hold = 1'b1;
    id = add(5'd3, 5'd1, 5'd2, 32'h0000_0040, 4'h0);
    #7;
    chk("rst_valid", act.valid, 1'b0);
    chk("rst_pc", act.pc, 32'h0);
    chk("rst_stall_hold", stall, 1'b0);
    chk("rst_bubbles", bubble_count, 16'h0);
    ex_hold = 1'b0;
    id = lw(5'd5, 5'd1, 32'h0000_0100);
    #5 rst_n = 1'b1;
    cyc();
    chk("first_capture_valid", act.valid, 1'b1);
    chk("first_capture_pc", act.pc, 32'h0000_0100);
    chk("first_capture_memread", act.memread, 1'b1);

    // Load-use on rs1: one bubble, then the add moves through
    id = add(5'd6, 5'd5, 5'd2, 32'h0000_0104, 4'h0);
    #1 chk("lu_stall", stall, 1'b1);
    cyc();
    chk("lu_bubble_valid", act.valid, 1'b0);
    chk("lu_bubble_count", bubble_count, 16'd1);
    chk("lu_stall_after", stall, 1'b0);
    cyc();
    chk("lu_add_rd", act.rd, 5'd6);
    chk("lu_add_aluop", act.aluop, 2'b10);

    // rd=0 load never hazards; store uses rs2 even with alusrc=1
    id = lw(5'd0, 5'd1, 32'h0000_0108);
    cyc();
    id = add(5'd8, 5'd0, 5'd0, 32'h0000_010C, 4'h0);
    #1 chk("x0_no_stall", stall, 1'b0);
    cyc();
    chk("x0_captured", act.rd, 5'd8);
    id = lw(5'd7, 5'd1, 32'h0000_0110);
    cyc();
    id = addi(5'd9, 5'd3, 5'd7, 32'h0000_0114);
    #1 chk("addi_rs2_ignored", stall, 1'b0);
    id = sw(5'd3, 5'd7, 32'h0000_0118);
    #1 chk("sw_rs2_stall", stall, 1'b1);
    cyc();
    chk("sw_bubble_count", bubble_count, 16'd2);
    cyc();
    chk("sw_memwrite", act.memwrite, 1'b1);
    chk("sw_memtoreg_forced", act.memtoreg, 1'b0);

    // flush beats both hold and load-use
    id = lw(5'd5, 5'd1, 32'h0000_0120);
    cyc();
    id = add(5'd6, 5'd5, 5'd2, 32'h0000_0124, 4'h0);
    flush = 1'b1; ex_hold = 1'b1;
    #1 chk("flush_stall", stall, 1'b0);
    cyc();
    chk("flush_valid", act.valid, 1'b0);
    chk("flush_count_1", flush_count, 16'd1);
    chk("flush_bubbles_same", bubble_count, 16'd2);
    flush = 1'b0; ex_hold = 1'b0;

    // Three-cycle hold with an R-type in EX
    id = add(5'd10, 5'd11, 5'd12, 32'h0000_0130, 4'h8);
    cyc();
    ex_hold = 1'b1;
    id = lw(5'd13, 5'd10, 32'h0000_0134);
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_stall", stall, 1'b1);
      cyc();
      chk("hold_rd", act.rd, 5'd10);
      chk("hold_funct", act.funct, 4'h8);
    end
    chk("hold_counts", {bubble_count, flush_count}, {16'd2, 16'd1});
    ex_hold = 1'b0;
    cyc();

    // id_valid=0 clears controls but still carries datapath
    id = lw(5'd14, 5'd1, 32'h0000_0140);
    id.valid = 1'b0;
    cyc();
    chk("inv_regwrite", act.regwrite, 1'b0);
    chk("inv_rd", act.rd, 5'd14);

    // Back-to-back dependent loads: a bubble every other edge
    id = lw(5'd5, 5'd5, 32'h0000_0150);
    for (int i = 0; i < 20; i++) cyc();
    chk("sat_bubble_7", sat_bubble_count, 3'd7);
    chk("main_bubble_12", bubble_count, 16'd12);
    flush = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
    chk("sat_flush_7", sat_flush_count, 3'd7);
    chk("main_flush_9", flush_count, 16'd9);
    flush = 1'b0;

    // Asynchronous reset mid-hold, then capture on the first edge after release
    id = add(5'd20, 5'd21, 5'd22, 32'h0000_0160, 4'h0);
    cyc();
    ex_hold = 1'b1;
    cyc();
    #3 rst_n = 1'b0;
    #1;
    chk("async_valid", act.valid, 1'b0);
    chk("async_pc", act.pc, 32'h0);
    chk("async_counts", {bubble_count, flush_count}, 32'h0);
    chk("async_stall", stall, 1'b0);
    cyc();
    #3 rst_n = 1'b1;
    ex_hold = 1'b0;
    id = add(5'd23, 5'd1, 5'd2, 32'h0000_0200, 4'h0);
    cyc();
    chk("post_rst_valid", act.valid, 1'b1);
    chk("post_rst_pc", act.pc, 32'h0000_0200);
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
